// File: rtl/soc_multichan_timer.sv
// soc_multichan_timer: NUM_CH independent prescaled down-count timers on a 32-bit Avalon-MM slave.
// Revision: 1.0 - initial multichannel release.
`default_nettype none

module soc_multichan_timer #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int PRE_W      = 16,
  parameter int PERIOD_RST = 49999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [4:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  localparam logic [1:0]       REG_STATUS  = 2'd0;
  localparam logic [1:0]       REG_CONTROL = 2'd1;
  localparam logic [1:0]       REG_PERIOD  = 2'd2;
  localparam logic [1:0]       REG_SNAP    = 2'd3;
  localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(PERIOD_RST);

  logic [2:0]        ch;
  logic [1:0]        rsel;
  logic              wr;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] tick;
  logic              unused_wdata;

  logic [CNT_W-1:0] period_q [NUM_CH];
  logic [CNT_W-1:0] period_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q    [NUM_CH];
  logic [CNT_W-1:0] cnt_d    [NUM_CH];
  logic [CNT_W-1:0] snap_q   [NUM_CH];
  logic [CNT_W-1:0] snap_d   [NUM_CH];
  logic [PRE_W-1:0] presc_q  [NUM_CH];
  logic [PRE_W-1:0] presc_d  [NUM_CH];
  logic [PRE_W-1:0] pcnt_q   [NUM_CH];
  logic [PRE_W-1:0] pcnt_d   [NUM_CH];
  logic [NUM_CH-1:0] ito_q, ito_d, cont_q, cont_d, run_q, run_d;
  logic [NUM_CH-1:0] to_q, to_d, reload_q, reload_d;
  logic [31:0]       readdata_q, readdata_d;

  assign ch           = address[4:2];
  assign rsel         = address[1:0];
  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CH; i++) hit[i] = wr && (ch == 3'(i));
  end

  always_comb begin
    tick     = '0;
    ito_d    = ito_q;
    cont_d   = cont_q;
    run_d    = run_q;
    to_d     = to_q;
    reload_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      period_d[i] = period_q[i];
      cnt_d[i]    = cnt_q[i];
      snap_d[i]   = snap_q[i];
      presc_d[i]  = presc_q[i];
      pcnt_d[i]   = pcnt_q[i];
      tick[i]     = run_q[i] && (pcnt_q[i] == presc_q[i]);

      if (hit[i] && rsel == REG_CONTROL) begin
        ito_d[i]   = writedata[0];
        cont_d[i]  = writedata[1];
        presc_d[i] = writedata[16 +: PRE_W];
      end
      if (hit[i] && rsel == REG_PERIOD) begin
        period_d[i] = writedata[CNT_W-1:0];
        reload_d[i] = 1'b1;
      end
      if (hit[i] && rsel == REG_SNAP) snap_d[i] = cnt_q[i];

      if (reload_q[i]) begin
        cnt_d[i]  = period_q[i];
        pcnt_d[i] = '0;
        run_d[i]  = 1'b0;
      end else if (tick[i]) begin
        pcnt_d[i] = '0;
        if (cnt_q[i] == '0) begin
          cnt_d[i] = period_q[i];
          to_d[i]  = 1'b1;
          run_d[i] = cont_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end else if (run_q[i]) begin
        pcnt_d[i] = pcnt_q[i] + 1'b1;
      end

      // START dominates STOP and a coincident one-shot expiry; a pending reload still wins.
      if (hit[i] && rsel == REG_CONTROL && !reload_q[i]) begin
        if (writedata[2])      run_d[i] = 1'b1;
        else if (writedata[3]) run_d[i] = 1'b0;
      end
      if (hit[i] && rsel == REG_STATUS) to_d[i] = 1'b0;
    end
  end

  // Read mux sees pre-write state; out-of-range channels fall through to zero.
  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == 3'(i)) begin
        case (rsel)
          REG_STATUS:  readdata_d = {30'b0, run_q[i], to_q[i]};
          REG_CONTROL: begin
            readdata_d[0]          = ito_q[i];
            readdata_d[1]          = cont_q[i];
            readdata_d[16 +: PRE_W] = presc_q[i];
          end
          REG_PERIOD:  readdata_d = 32'(period_q[i]);
          default:     readdata_d = 32'(snap_q[i]);
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ito_q      <= '0;
      cont_q     <= '0;
      run_q      <= '0;
      to_q       <= '0;
      reload_q   <= '0;
      readdata_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i] <= PERIOD_INIT;
        cnt_q[i]    <= PERIOD_INIT;
        snap_q[i]   <= '0;
        presc_q[i]  <= '0;
        pcnt_q[i]   <= '0;
      end
    end else begin
      ito_q      <= ito_d;
      cont_q     <= cont_d;
      run_q      <= run_d;
      to_q       <= to_d;
      reload_q   <= reload_d;
      readdata_q <= readdata_d;
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i] <= period_d[i];
        cnt_q[i]    <= cnt_d[i];
        snap_q[i]   <= snap_d[i];
        presc_q[i]  <= presc_d[i];
        pcnt_q[i]   <= pcnt_d[i];
      end
    end
  end

  assign readdata = readdata_q;
  assign irq_vec  = to_q & ito_q;
  assign irq      = |irq_vec;

endmodule

`default_nettype wire

// File: tb/tb_soc_multichan_timer.sv
// Directed bench for soc_multichan_timer: bus reads/writes plus irq observation at fixed clock offsets.
`default_nettype none

module tb_soc_multichan_timer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  irq_vec;

  int checks = 0;
  int errors = 0;

  soc_multichan_timer #(
    .NUM_CH(4), .CNT_W(32), .PRE_W(16), .PERIOD_RST(49999)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vec    (irq_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int c, input int r, input logic [31:0] d);
    address    = {c[2:0], r[1:0]};
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rdchk(input string tag, input int c, input int r, input logic [31:0] exp);
    address    = {c[2:0], r[1:0]};
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    chk(tag, readdata, exp);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    step(3);
    reset_n = 1'b1;

    // Reset state
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_irq_vec", {28'd0, irq_vec}, 32'd0);
    rdchk("rst_ch0_period", 0, 2, 32'd49999);
    rdchk("rst_ch0_status", 0, 0, 32'd0);
    rdchk("rst_ch0_ctrl", 0, 1, 32'd0);
    rdchk("rst_ch0_snap", 0, 3, 32'd0);

    // Continuous timeout on ch1, period 9
    wr(1, 2, 32'd9);
    step(1);
    wr(1, 1, 32'h0000_0007);
    step(9);
    chk("cont_before_to", {28'd0, irq_vec}, 32'h0);
    step(1);
    chk("cont_first_to", {28'd0, irq_vec}, 32'h2);
    chk("cont_irq", {31'd0, irq}, 32'd1);
    wr(1, 0, 32'd0);
    chk("cont_to_cleared", {28'd0, irq_vec}, 32'h0);
    step(8);
    chk("cont_before_2nd", {28'd0, irq_vec}, 32'h0);
    step(1);
    chk("cont_second_to", {28'd0, irq_vec}, 32'h2);
    wr(1, 1, 32'h0000_0008);
    rdchk("cont_stopped_status", 1, 0, 32'd1);
    wr(1, 0, 32'd0);
    chk("cont_irq_off", {31'd0, irq}, 32'd0);

    // Prescaler 2, period 3, one-shot on ch2: timeout 12 clocks after START
    wr(2, 2, 32'd3);
    step(1);
    wr(2, 1, 32'h0002_0004);
    for (int k = 0; k < 12; k++) rdchk("pre_running", 2, 0, 32'd2);
    rdchk("pre_expired", 2, 0, 32'd1);
    wr(2, 3, 32'd0);
    rdchk("pre_snap", 2, 3, 32'd3);
    rdchk("pre_ctrl_readback", 2, 1, 32'h0002_0000);
    wr(2, 0, 32'd0);

    // START|STOP together leaves channel running
    wr(2, 1, 32'h0000_000C);
    rdchk("startstop_run", 2, 0, 32'd2);
    wr(2, 1, 32'h0000_0008);
    rdchk("stop_status", 2, 0, 32'd0);

    // START coincident with one-shot expiry (counter now 1, prescale 0)
    wr(2, 1, 32'h0000_0004);
    step(1);
    wr(2, 1, 32'h0000_0004);
    rdchk("start_on_expiry", 2, 0, 32'd3);
    wr(2, 1, 32'h0000_0008);
    wr(2, 0, 32'd0);

    // PERIOD write mid-run on ch0
    wr(0, 2, 32'd100);
    step(1);
    wr(0, 1, 32'h0000_0004);
    step(3);
    wr(0, 2, 32'd5);
    step(1);
    rdchk("midrun_status", 0, 0, 32'd0);
    wr(0, 3, 32'd0);
    rdchk("midrun_snap", 0, 3, 32'd5);
    rdchk("midrun_period", 0, 2, 32'd5);

    // STATUS write in the timeout cycle on ch3 (period 2)
    wr(3, 2, 32'd2);
    step(1);
    wr(3, 1, 32'h0000_0007);
    step(2);
    wr(3, 0, 32'd0);
    chk("clear_wins", {28'd0, irq_vec}, 32'h0);
    step(2);
    chk("clear_wins_hold", {28'd0, irq_vec}, 32'h0);
    step(1);
    chk("clear_wins_next_to", {28'd0, irq_vec}, 32'h8);
    wr(3, 1, 32'h0000_0008);
    wr(3, 0, 32'd0);

    // Nonexistent channel 7
    rdchk("ch7_period", 7, 2, 32'd0);
    wr(7, 2, 32'h55);
    wr(7, 1, 32'h0000_0007);
    rdchk("ch7_after_write", 7, 2, 32'd0);
    rdchk("ch3_period_intact", 3, 2, 32'd2);
    rdchk("ch3_status_intact", 3, 0, 32'd0);

    // Independence: ch0 period 4, ch3 period 6
    wr(0, 2, 32'd4);
    wr(3, 2, 32'd6);
    step(1);
    wr(0, 1, 32'h0000_0007);
    wr(3, 1, 32'h0000_0007);
    step(3);
    chk("ind_idle", {28'd0, irq_vec}, 32'h0);
    step(1);
    chk("ind_ch0_first", {28'd0, irq_vec}, 32'h1);
    chk("ind_irq_ch0", {31'd0, irq}, 32'd1);
    wr(0, 0, 32'd0);
    chk("ind_ch0_clear", {28'd0, irq_vec}, 32'h0);
    step(1);
    chk("ind_pre_ch3", {28'd0, irq_vec}, 32'h0);
    step(1);
    chk("ind_ch3_first", {28'd0, irq_vec}, 32'h8);
    step(2);
    chk("ind_both", {28'd0, irq_vec}, 32'h9);
    chk("ind_irq_both", {31'd0, irq}, 32'd1);
    wr(0, 1, 32'h0000_0002);
    chk("ind_ito_off", {28'd0, irq_vec}, 32'h8);
    wr(3, 0, 32'd0);
    chk("ind_all_clear", {28'd0, irq_vec}, 32'h0);
    chk("ind_irq_low", {31'd0, irq}, 32'd0);
    step(2);
    chk("ind_pre_ch3_2nd", {28'd0, irq_vec}, 32'h0);
    step(1);
    chk("ind_ch3_second", {28'd0, irq_vec}, 32'h8);
    chk("ind_irq_ch3_only", {31'd0, irq}, 32'd1);

    // Asynchronous reset mid-count
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_irq_vec", {28'd0, irq_vec}, 32'h0);
    chk("async_irq", {31'd0, irq}, 32'd0);
    chk("async_readdata", readdata, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rdchk("post_rst_period", 3, 2, 32'd49999);
    rdchk("post_rst_status", 0, 0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
